huffman_canon_decoder: RTL



---
 rtl/huffman_pkg.sv | 19 +
 rtl/huffman_bit_buffer.sv | 59 +++++
 rtl/huffman_canon_decoder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/huffman_pkg.sv
// Shared definitions for the canonical Huffman decoder: FSM states, default
// geometry and the canonical-index width helper.
package huffman_pkg;

    typedef enum logic [1:0] {
        S_CFG,
        S_BUILD,
        S_RUN,
        S_ERR
    } state_t;

    localparam int DEF_MAX_CODE = 9;
    localparam int DEF_SYM_W    = 4;

    function automatic int canon_idx_w(input int num_syms);
        return (num_syms > 1) ? $clog2(num_syms) : 1;
    endfunction

endpackage

// File: rtl/huffman_bit_buffer.sv
// MSB-aligned bit buffer: buf_data[BUF_W-1] is the oldest bit. Shifts out a
// decoded code and appends a new chunk behind the remaining bits in one cycle.
module huffman_bit_buffer #(
    parameter int BUF_W = 13,
    parameter int IN_W  = 4,
    parameter int LEN_W = 3,
    parameter int SH_W  = 4,
    parameter int BCW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             shift_en,
    input  logic [SH_W-1:0]  shift_len,
    input  logic             load_en,
    input  logic [IN_W-1:0]  load_data,
    input  logic [LEN_W-1:0] load_len,
    output logic [BUF_W-1:0] buf_data,
    output logic [BCW-1:0]   bit_count
);

    logic [BCW-1:0]   shift_amt;
    logic [BCW-1:0]   load_amt;
    logic [BCW-1:0]   remain;
    logic [IN_W-1:0]  chunk;
    logic [BUF_W-1:0] shifted;
    logic [BUF_W-1:0] placed;
    logic [BUF_W-1:0] buf_next;
    logic [BCW-1:0]   count_next;

    always_comb begin
        shift_amt  = shift_en ? BCW'(shift_len) : '0;
        load_amt   = load_en ? BCW'(load_len) : '0;
        remain     = bit_count - shift_amt;
        // Bits of s_data above s_len are don't-care on the wire; drop them.
        chunk      = load_data & ~({IN_W{1'b1}} << load_len);
        shifted    = buf_data << shift_amt;
        placed     = '0;
        if (load_en) begin
            placed = BUF_W'(chunk) << (BCW'(BUF_W) - remain - load_amt);
        end
        buf_next   = shifted | placed;
        count_next = remain + load_amt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_data  <= '0;
            bit_count <= '0;
        end else if (flush) begin
            buf_data  <= '0;
            bit_count <= '0;
        end else begin
            buf_data  <= buf_next;
            bit_count <= count_next;
        end
    end

endmodule

// File: rtl/huffman_canon_decoder.sv
// Run-time programmable canonical Huffman decoder: loadable length/symbol
// tables, a one-length-per-cycle table build, and single-cycle parallel decode.
module huffman_canon_decoder
    import huffman_pkg::*;
#(
    parameter int MAX_CODE = DEF_MAX_CODE,
    parameter int SYM_W    = DEF_SYM_W,
    parameter int NUM_SYMS = 16,
    parameter int IN_W     = 4,
    localparam int IDX_W   = canon_idx_w(NUM_SYMS),
    localparam int CNT_W   = $clog2(NUM_SYMS + 1),
    localparam int LEN_W   = $clog2(IN_W + 1),
    localparam int LW      = $clog2(MAX_CODE + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_len_we,
    input  logic [LW-1:0]    cfg_len_idx,
    input  logic [CNT_W-1:0] cfg_len_count,
    input  logic             cfg_sym_we,
    input  logic [IDX_W-1:0] cfg_sym_addr,
    input  logic [SYM_W-1:0] cfg_sym_data,
    input  logic             cfg_commit,
    output logic             cfg_busy,
    output logic             cfg_err,
    output logic             dec_err,
    input  logic             s_valid,
    input  logic [IN_W-1:0]  s_data,
    input  logic [LEN_W-1:0] s_len,
    output logic             s_ready,
    output logic             m_valid,
    output logic [SYM_W-1:0] m_data,
    input  logic             m_ready
);

    localparam int BUF_W = MAX_CODE + IN_W;
    localparam int BCW   = $clog2(BUF_W + 1);
    localparam int FW    = MAX_CODE + 1;
    localparam int EW    = MAX_CODE + CNT_W + 2;

    state_t state_q, state_d;

    logic        [CNT_W-1:0] count_q [1:MAX_CODE];
    logic        [FW-1:0]    first_q [1:MAX_CODE];
    logic        [CNT_W-1:0] base_q  [1:MAX_CODE];
    logic signed [SYM_W-1:0] sym_q   [NUM_SYMS];

    logic [LW-1:0]    build_len;
    logic [FW-1:0]    acc_first;
    logic [CNT_W-1:0] acc_base;
    logic             kraft_bad;

    logic [BUF_W-1:0] buf_data;
    logic [BCW-1:0]   bit_count;

    logic                    hit;
    logic [LW-1:0]           hit_len;
    logic [EW-1:0]           hit_idx;
    logic [EW-1:0]           code_ext;
    logic [EW-1:0]           first_ext;
    logic signed [SYM_W-1:0] sym_out;

    logic commit_go;
    logic take;
    logic load_en;
    logic no_match;

    assign commit_go = cfg_commit && (state_q != S_BUILD);
    assign cfg_busy  = (state_q == S_BUILD);
    assign s_ready   = (state_q == S_RUN) && ((BCW'(BUF_W) - bit_count) >= BCW'(IN_W));
    assign load_en   = s_valid && s_ready && (s_len != '0) && (s_len <= LEN_W'(IN_W));
    assign take      = (state_q == S_RUN) && hit && (!m_valid || m_ready);
    assign no_match  = (state_q == S_RUN) && !hit && (bit_count >= BCW'(MAX_CODE));

    // Oversubscription check for the length currently being built.
    always_comb begin
        kraft_bad = 1'b0;
        if (state_q == S_BUILD) begin
            kraft_bad = (EW'(acc_first) + EW'(count_q[build_len])) > (EW'(1) << build_len);
        end
    end

    // All code lengths are compared in parallel; the shortest match wins.
    always_comb begin
        hit       = 1'b0;
        hit_len   = '0;
        hit_idx   = '0;
        code_ext  = '0;
        first_ext = '0;
        for (int l = 1; l <= MAX_CODE; l++) begin
            code_ext  = EW'(buf_data >> (BUF_W - l));
            first_ext = EW'(first_q[l]);
            if (!hit && (EW'(bit_count) >= EW'(l)) && (count_q[l] != '0) &&
                (code_ext >= first_ext) &&
                ((code_ext - first_ext) < EW'(count_q[l]))) begin
                hit     = 1'b1;
                hit_len = LW'(l);
                hit_idx = EW'(base_q[l]) + code_ext - first_ext;
            end
        end
        sym_out = '0;
        if (hit_idx < EW'(NUM_SYMS)) begin
            sym_out = sym_q[hit_idx[IDX_W-1:0]];
        end
    end

    huffman_bit_buffer #(
        .BUF_W(BUF_W),
        .IN_W (IN_W),
        .LEN_W(LEN_W),
        .SH_W (LW),
        .BCW  (BCW)
    ) u_bit_buffer (
        .clk      (clk),
        .reset    (reset),
        .flush    (commit_go),
        .shift_en (take),
        .shift_len(hit_len),
        .load_en  (load_en),
        .load_data(s_data),
        .load_len (s_len),
        .buf_data (buf_data),
        .bit_count(bit_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_CFG;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (commit_go) begin
            state_d = S_BUILD;
        end else begin
            case (state_q)
                S_BUILD: begin
                    if (kraft_bad) begin
                        state_d = S_ERR;
                    end else if (build_len == LW'(MAX_CODE)) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (no_match) begin
                        state_d = S_ERR;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int l = 1; l <= MAX_CODE; l++) begin
                count_q[l] <= '0;
                first_q[l] <= '0;
                base_q[l]  <= '0;
            end
            for (int i = 0; i < NUM_SYMS; i++) begin
                sym_q[i] <= '0;
            end
            build_len <= '0;
            acc_first <= '0;
            acc_base  <= '0;
            cfg_err   <= 1'b0;
            dec_err   <= 1'b0;
            m_valid   <= 1'b0;
            m_data    <= '0;
        end else begin
            if (cfg_len_we && (state_q != S_BUILD) && (cfg_len_idx != '0) &&
                (cfg_len_idx <= LW'(MAX_CODE))) begin
                count_q[cfg_len_idx] <= cfg_len_count;
            end
            if (cfg_sym_we && (state_q != S_BUILD) && (EW'(cfg_sym_addr) < EW'(NUM_SYMS))) begin
                sym_q[cfg_sym_addr] <= cfg_sym_data;
            end
            if (commit_go) begin
                build_len <= LW'(1);
                acc_first <= '0;
                acc_base  <= '0;
                cfg_err   <= 1'b0;
                dec_err   <= 1'b0;
                m_valid   <= 1'b0;
            end else begin
                if (state_q == S_BUILD) begin
                    first_q[build_len] <= acc_first;
                    base_q[build_len]  <= acc_base;
                    acc_first <= FW'((acc_first + FW'(count_q[build_len])) << 1);
                    acc_base  <= acc_base + count_q[build_len];
                    build_len <= build_len + LW'(1);
                    if (kraft_bad) begin
                        cfg_err <= 1'b1;
                    end
                end
                if (no_match) begin
                    dec_err <= 1'b1;
                end
                // A new symbol replaces the old one on the handshake edge.
                if (take) begin
                    m_valid <= 1'b1;
                    m_data  <= sym_out;
                end else if (m_ready) begin
                    m_valid <= 1'b0;
                end
            end
        end
    end

endmodule
